// File: rtl/vga_scaled_display_pkg.sv
// Shared constants for the VGA scan-out engine: 640x480@60 default timing,
// output modes and the colour-bar palette.
package vga_scaled_display_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int NUM_BARS = 8;

    typedef enum logic [1:0] {
        MODE_GRAY  = 2'd0,
        MODE_INV   = 2'd1,
        MODE_BARS  = 2'd2,
        MODE_BLACK = 2'd3
    } mode_e;

    // {r,g,b} on/off per bar, index 0 (white) in the LSBs
    localparam logic [NUM_BARS-1:0][2:0] BAR_RGB = {
        3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
    };

    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        return BAR_RGB[idx];
    endfunction

endpackage

// File: rtl/vga_scaled_display_pipe_delay.sv
// Generic fixed-depth delay line with a parametrised reset value.
module pipe_delay #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             vga_clk_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [DEPTH-1:0][WIDTH-1:0] dly_pipe;

    always_ff @(posedge vga_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < DEPTH; i++) dly_pipe[i] <= RST_VAL;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) dly_pipe[i] <= dly_pipe[i-1];
            dly_pipe[0] <= d;
        end
    end

    assign q = dly_pipe[DEPTH-1];

endmodule

// File: rtl/vga_scaled_display_timing_gen.sv
// Raster counters with sync and blank decode; shared by the display blocks.
module vga_timing_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit SYNC_ACTIVE = 1'b0,
    parameter int HW          = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int VW          = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          vga_clk_in,
    input  logic          rst_n_in,
    output logic [HW-1:0] hcount,
    output logic [VW-1:0] vcount,
    output logic          hs,
    output logic          vs,
    output logic          blank,
    output logic          line_end,
    output logic          frame_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    always_ff @(posedge vga_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hcount <= '0;
            vcount <= '0;
        end else if (line_end) begin
            hcount <= '0;
            vcount <= frame_end ? '0 : vcount + 1'b1;
        end else begin
            hcount <= hcount + 1'b1;
        end
    end

    assign line_end  = (int'(hcount) == H_TOTAL - 1);
    assign frame_end = line_end && (int'(vcount) == V_TOTAL - 1);
    assign blank     = !((int'(hcount) < H_ACTIVE) && (int'(vcount) < V_ACTIVE));

    assign hs = ((int'(hcount) >= H_ACTIVE + H_FP) &&
                 (int'(hcount) <  H_ACTIVE + H_FP + H_SYNC)) ? SYNC_ACTIVE : !SYNC_ACTIVE;
    assign vs = ((int'(vcount) >= V_ACTIVE + V_FP) &&
                 (int'(vcount) <  V_ACTIVE + V_FP + V_SYNC)) ? SYNC_ACTIVE : !SYNC_ACTIVE;

endmodule

// File: rtl/vga_scaled_display.sv
// VGA scan-out: upscaled framebuffer fetch, double-buffer select, output modes.
module vga_scaled_display
    import vga_scaled_display_pkg::*;
#(
    parameter int  H_ACTIVE    = DEF_H_ACTIVE,
    parameter int  H_FP        = DEF_H_FP,
    parameter int  H_SYNC      = DEF_H_SYNC,
    parameter int  H_BP        = DEF_H_BP,
    parameter int  V_ACTIVE    = DEF_V_ACTIVE,
    parameter int  V_FP        = DEF_V_FP,
    parameter int  V_SYNC      = DEF_V_SYNC,
    parameter int  V_BP        = DEF_V_BP,
    parameter int  SCALE_LOG2  = 2,
    parameter int  PIX_BITS    = 4,
    parameter int  MEM_LATENCY = 2,
    parameter bit  SYNC_ACTIVE = 1'b0,
    localparam int FB_W        = H_ACTIVE >> SCALE_LOG2,
    localparam int FB_H        = V_ACTIVE >> SCALE_LOG2,
    localparam int ADDR_BITS   = $clog2(2 * FB_W * FB_H)
) (
    input  logic                 vga_clk_in,
    input  logic                 rst_n_in,
    input  logic                 buf_sel_in,
    input  logic [1:0]           mode_in,
    output logic [ADDR_BITS-1:0] read_addr_out,
    input  logic [PIX_BITS-1:0]  read_data_in,
    output logic                 frame_done_out,
    output logic                 buf_active_out,
    output logic [3:0]           vga_r,
    output logic [3:0]           vga_g,
    output logic [3:0]           vga_b,
    output logic                 vga_hs,
    output logic                 vga_vs
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / NUM_BARS;
    localparam int BW      = $clog2(BAR_W + 1);
    localparam int SB_W    = 6;

    localparam logic [ADDR_BITS-1:0] FB_OFS   = ADDR_BITS'(FB_W * FB_H);
    localparam logic [ADDR_BITS-1:0] ROW_STEP = ADDR_BITS'(FB_W);
    localparam logic [VW-1:0]        V_MASK   = VW'((1 << SCALE_LOG2) - 1);
    localparam logic [SB_W-1:0]      SB_RST   = {!SYNC_ACTIVE, !SYNC_ACTIVE, 1'b1, 3'b000};

    logic [HW-1:0]        hcount;
    logic [VW-1:0]        vcount;
    logic                 t_hs, t_vs, t_blank, line_end, frame_end;
    logic [BW-1:0]        bar_cnt;
    logic [2:0]           bar_idx;
    logic [ADDR_BITS-1:0] row_base;
    logic                 frame_start, buf_cur;
    logic                 p_hs, p_vs, p_blank;
    logic [2:0]           p_bar, bar_on;
    logic [3:0]           gray, nr, ng, nb;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_ACTIVE(SYNC_ACTIVE), .HW(HW), .VW(VW)
    ) u_timing (
        .vga_clk_in(vga_clk_in), .rst_n_in(rst_n_in),
        .hcount(hcount), .vcount(vcount), .hs(t_hs), .vs(t_vs), .blank(t_blank),
        .line_end(line_end), .frame_end(frame_end)
    );

    // Bar index tracked alongside hcount so no divide by BAR_W is needed
    always_ff @(posedge vga_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bar_cnt <= '0;
            bar_idx <= '0;
        end else if (line_end) begin
            bar_cnt <= '0;
            bar_idx <= '0;
        end else if (bar_cnt == BW'(BAR_W - 1)) begin
            bar_cnt <= '0;
            bar_idx <= bar_idx + 1'b1;
        end else begin
            bar_cnt <= bar_cnt + 1'b1;
        end
    end

    // The new selection already applies to the (0,0) fetch it is latched on
    assign frame_start = (hcount == '0) && (vcount == '0);
    assign buf_cur     = frame_start ? buf_sel_in : buf_active_out;

    always_ff @(posedge vga_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            buf_active_out <= 1'b0;
            row_base       <= '0;
            read_addr_out  <= '0;
        end else begin
            if (frame_start)
                buf_active_out <= buf_sel_in;
            if (frame_end)
                row_base <= '0;
            else if (line_end && int'(vcount) < V_ACTIVE && (vcount & V_MASK) == V_MASK)
                row_base <= row_base + ROW_STEP;
            if (!t_blank)
                read_addr_out <= (buf_cur ? FB_OFS : '0) + row_base +
                                 ADDR_BITS'(hcount >> SCALE_LOG2);
        end
    end

    assign frame_done_out = (hcount == '0) && (int'(vcount) == V_ACTIVE);

    // Sideband rides alongside the address reg and BRAM; the colour reg adds the last cycle
    pipe_delay #(.WIDTH(SB_W), .DEPTH(MEM_LATENCY + 1), .RST_VAL(SB_RST)) u_sb_dly (
        .vga_clk_in(vga_clk_in), .rst_n_in(rst_n_in),
        .d({t_hs, t_vs, t_blank, bar_idx}),
        .q({p_hs, p_vs, p_blank, p_bar})
    );

    generate
        if (PIX_BITS >= 4) begin : g_trunc
            assign gray = read_data_in[PIX_BITS-1 -: 4];
        end else begin : g_pad
            assign gray = {read_data_in, {(4 - PIX_BITS){1'b0}}};
        end
    endgenerate

    always_comb begin
        nr     = '0;
        ng     = '0;
        nb     = '0;
        bar_on = bar_rgb(p_bar);
        if (!p_blank) begin
            case (mode_in)
                MODE_GRAY: begin nr = gray;  ng = gray;  nb = gray;  end
                MODE_INV:  begin nr = ~gray; ng = ~gray; nb = ~gray; end
                MODE_BARS: begin
                    nr = {4{bar_on[2]}};
                    ng = {4{bar_on[1]}};
                    nb = {4{bar_on[0]}};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge vga_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
            vga_hs <= !SYNC_ACTIVE;
            vga_vs <= !SYNC_ACTIVE;
        end else begin
            vga_r  <= nr;
            vga_g  <= ng;
            vga_b  <= nb;
            vga_hs <= p_hs;
            vga_vs <= p_vs;
        end
    end

endmodule

// File: tb/tb_vga_scaled_display.sv
// Directed bench for vga_scaled_display on a reduced 32x16 raster (48x24 total), 4x upscale.
module tb_vga_scaled_display;

    localparam int HT = 48;
    localparam int VT = 24;
    localparam int FR = HT * VT;

    logic       clk = 1'b0;
    logic       rst_n_in;
    logic       buf_sel_in;
    logic [1:0] mode_in;
    logic [5:0] read_addr_out;
    logic [3:0] read_data_in;
    logic       frame_done_out, buf_active_out;
    logic [3:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs;

    vga_scaled_display #(
        .H_ACTIVE(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(16), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .SCALE_LOG2(2), .PIX_BITS(4), .MEM_LATENCY(2), .SYNC_ACTIVE(1'b0)
    ) dut (
        .vga_clk_in(clk), .rst_n_in(rst_n_in), .buf_sel_in(buf_sel_in), .mode_in(mode_in),
        .read_addr_out(read_addr_out), .read_data_in(read_data_in),
        .frame_done_out(frame_done_out), .buf_active_out(buf_active_out),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs)
    );

    always #5 clk = ~clk;

    // BRAM model, 2-cycle latency, word = low address bits
    logic [5:0] d1, d2;
    always @(posedge clk) begin
        d1 <= read_addr_out;
        d2 <= d1;
    end
    assign read_data_in = d2[3:0];

    // Edges since reset release: during interval ne the counters sit at raster index ne
    int ne;
    always @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) ne <= 0;
        else           ne <= ne + 1;
    end

    int fd_cnt = 0;
    int fd_last = -1;
    always @(negedge clk) begin
        if (rst_n_in && frame_done_out) begin
            fd_cnt  = fd_cnt + 1;
            fd_last = ne;
        end
    end

    int nvec = 0;
    int nfail = 0;

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        nvec = nvec + 1;
        if (act != exp) begin
            nfail = nfail + 1;
            $display("FAIL %s[%0d]: got %0d, want %0d", nm, idx, act, exp);
        end
    endtask

    task automatic wait_ne(input int t);
        int g = 0;
        while (ne < t && g < 20000) begin
            @(negedge clk);
            g++;
        end
        if (ne != t) chk("wait_ne", t, ne, t);
    endtask

    typedef struct {
        int mode;
        int h, v;
        int addr;
        int r, g, b;
        int hs, vs;
    } vec_t;

    vec_t tbl[13];
    int p, fdsnap;

    initial begin
        // mode, h, v, addr, r, g, b, hs, vs  (all in frame 0, buffer 0)
        tbl[0]  = '{0,  0,  0,  0,  0,  0,  0, 1, 1};
        tbl[1]  = '{0,  5,  0,  1,  1,  1,  1, 1, 1};
        tbl[2]  = '{0, 31,  3,  7,  7,  7,  7, 1, 1};
        tbl[3]  = '{0, 13,  4, 11, 11, 11, 11, 1, 1};
        tbl[4]  = '{1, 20,  6, 13,  2,  2,  2, 1, 1};
        tbl[5]  = '{0, 36,  6, 15,  0,  0,  0, 0, 1};
        tbl[6]  = '{2,  4,  8, 17, 15, 15,  0, 1, 1};
        tbl[7]  = '{2, 30,  8, 23,  0,  0,  0, 1, 1};
        tbl[8]  = '{2, 12,  9, 19,  0, 15,  0, 1, 1};
        tbl[9]  = '{3, 20, 12, 29,  0,  0,  0, 1, 1};
        tbl[10] = '{0, 31, 15, 31, 15, 15, 15, 1, 1};
        tbl[11] = '{2, 10, 18, 31,  0,  0,  0, 1, 0};
        tbl[12] = '{1, 40, 19, 31,  0,  0,  0, 0, 0};

        rst_n_in   = 1'b0;
        buf_sel_in = 1'b0;
        mode_in    = 2'd0;
        repeat (5) @(negedge clk);
        chk("rst_hs", 0, vga_hs, 1);
        chk("rst_vs", 0, vga_vs, 1);
        chk("rst_rgb", 0, {vga_r, vga_g, vga_b}, 0);
        chk("rst_addr", 0, read_addr_out, 0);
        chk("rst_fdone", 0, frame_done_out, 0);
        chk("rst_buf", 0, buf_active_out, 0);
        rst_n_in = 1'b1;

        for (int i = 0; i < 13; i++) begin
            mode_in = 2'(tbl[i].mode);
            p = tbl[i].v * HT + tbl[i].h;
            wait_ne(p + 1);
            chk("addr", i, read_addr_out, tbl[i].addr);
            wait_ne(p + 4);
            chk("r", i, vga_r, tbl[i].r);
            chk("g", i, vga_g, tbl[i].g);
            chk("b", i, vga_b, tbl[i].b);
            chk("hs", i, vga_hs, tbl[i].hs);
            chk("vs", i, vga_vs, tbl[i].vs);
        end

        // latency: pixel 3 reads word 0, pixel 4 reads word 1, hs lands 4 cycles after h=36
        mode_in = 2'd0;
        wait_ne(FR + 3 + 4);
        chk("lat_px3", 0, vga_r, 0);
        wait_ne(FR + 4 + 4);
        chk("lat_px4", 0, vga_r, 1);
        wait_ne(FR + 35 + 4);
        chk("lat_hs35", 0, vga_hs, 1);
        wait_ne(FR + 36 + 4);
        chk("lat_hs36", 0, vga_hs, 0);

        // buffer switch mid-frame only applies from the next frame
        wait_ne(FR + 50);
        buf_sel_in = 1'b1;
        wait_ne(FR + 2 * HT + 5 + 1);
        chk("buf_hold_addr", 0, read_addr_out, 1);
        chk("buf_hold_act", 0, buf_active_out, 0);
        wait_ne(2 * FR + 2 * HT + 5 + 1);
        chk("buf_sw_addr", 0, read_addr_out, 33);
        chk("buf_sw_act", 0, buf_active_out, 1);
        buf_sel_in = 1'b0;
        wait_ne(2 * FR + 15 * HT + 31 + 1);
        chk("buf_last_addr", 0, read_addr_out, 63);
        chk("buf_keep_act", 0, buf_active_out, 1);

        // frame_done: one pulse per frame at (0,16)
        wait_ne(2 * FR + 16 * HT - 1);
        chk("fdone_pre", 0, frame_done_out, 0);
        wait_ne(2 * FR + 16 * HT);
        chk("fdone", 0, frame_done_out, 1);
        wait_ne(2 * FR + 16 * HT + 1);
        chk("fdone_post", 0, frame_done_out, 0);
        wait_ne(2 * FR + 16 * HT + 8);
        chk("fdone_cnt", 0, fd_cnt, 3);
        chk("fdone_last", 0, fd_last, 2 * FR + 16 * HT);

        // reset mid-frame at vcount=10
        wait_ne(3 * FR + 10 * HT);
        rst_n_in = 1'b0;
        #1;
        chk("mrst_addr", 0, read_addr_out, 0);
        chk("mrst_hs", 0, vga_hs, 1);
        chk("mrst_vs", 0, vga_vs, 1);
        chk("mrst_rgb", 0, {vga_r, vga_g, vga_b}, 0);
        chk("mrst_buf", 0, buf_active_out, 0);
        repeat (3) @(negedge clk);
        rst_n_in = 1'b1;
        fdsnap = fd_cnt;
        wait_ne(6);
        chk("mrst_restart_addr", 0, read_addr_out, 1);
        wait_ne(16 * HT - 1);
        chk("mrst_no_pulse", 0, fd_cnt, fdsnap);
        wait_ne(16 * HT);
        chk("mrst_fdone", 0, frame_done_out, 1);

        // buffer 1 chosen at the first post-reset (0,0)
        buf_sel_in = 1'b1;
        rst_n_in   = 1'b0;
        @(negedge clk);
        rst_n_in = 1'b1;
        wait_ne(6);
        chk("rst_buf1_addr", 0, read_addr_out, 33);
        chk("rst_buf1_act", 0, buf_active_out, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/vga_scaled_display.md
Name: vga_scaled_display

Overview:
Parametrised VGA scan-out engine. It generates its own timing, fetches pixels from a framebuffer BRAM, and drives the VGA pins. It supports integer upscaling (a framebuffer smaller than the screen), double-buffered frame selection, and several output modes. It sits between the ray-marcher framebuffer (dual-port BRAM, read port) and the top-level VGA pins, entirely in the pixel clock domain.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (cycles)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
SCALE_LOG2, 2, upscale factor 2^SCALE_LOG2 in both axes; FB_W=H_ACTIVE>>SCALE_LOG2, FB_H=V_ACTIVE>>SCALE_LOG2
PIX_BITS, 4, grayscale bits per framebuffer word
MEM_LATENCY, 2, BRAM read latency in cycles (1..4)
SYNC_ACTIVE, 0, asserted level of hs/vs

Ports:
vga_clk_in  in  1  pixel clock
rst_n_in  in  1  asynchronous active-low reset
buf_sel_in  in  1  framebuffer half to display next frame
mode_in  in  2  0=gray, 1=inverted gray, 2=colour bars, 3=black
read_addr_out  out  ADDR_BITS  BRAM read address, ADDR_BITS=$clog2(2*FB_W*FB_H)
read_data_in  in  PIX_BITS  BRAM read data
frame_done_out  out  1  one-cycle pulse at first blanking line after last active line
buf_active_out  out  1  buffer currently being scanned
vga_r, vga_g, vga_b  out  4 each  colour
vga_hs, vga_vs  out  1 each  sync

Behaviour:
- Reset (async assert, sync release): hcount=vcount=0, row_base=0, buf_active_out=0, read_addr_out=0, colours=0, hs/vs=~SYNC_ACTIVE, frame_done_out=0, all pipeline stages blank=1.
- Timing: hcount 0..H_TOTAL-1, wraps and increments vcount; vcount wraps at V_TOTAL-1. Active when hcount<H_ACTIVE and vcount<V_ACTIVE. hs asserted for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vs likewise on vcount.
- Address: read_addr_out = buf_active_out*FB_W*FB_H + row_base + (hcount>>SCALE_LOG2), registered one cycle after the counters.
- row_base update: no multiplier. It advances by FB_W when the line ends, vcount<V_ACTIVE, and the low SCALE_LOG2 bits of vcount are all ones. It clears at vcount wrap.
- During blanking, read_addr_out holds its last value.
- Buffer latch: buf_sel_in is sampled into buf_active_out only at hcount=0,vcount=0. Changes mid-frame are ignored until the next frame.
- Pipeline: counter stage -> address reg -> MEM_LATENCY BRAM cycles -> colour reg. Total latency from counters to pins is L=MEM_LATENCY+2. hs, vs and blank are delayed by exactly L in a shift register, so the pixel for (h,v) and its sync/blank appear on the same cycle.
- Colour (blank forces 0 regardless of mode). The gray value g is read_data_in left-aligned to 4 bits, zero-padded if PIX_BITS<4 or truncated to MSBs if PIX_BITS>4.
  - Mode 0: r=g=b=g.
  - Mode 1: r=g=b=~g.
  - Mode 2: 8 vertical bars of width H_ACTIVE/8 in order white, yellow, cyan, green, magenta, red, blue, black, at full 4'hF intensity. The bar index is computed from the delayed hcount, and memory data is ignored.
  - Mode 3: all zero.
  - mode_in is sampled at the colour stage, so a change takes effect on the next pixel.
- frame_done_out: pulses for one cycle when the counter stage reaches hcount=0, vcount=V_ACTIVE. It is not delayed.
- Reset mid-frame: everything returns to reset values immediately, and scanning restarts at (0,0) with buffer 0 unless buf_sel_in=1 at the first post-reset (0,0).

Decomposition:
- Shared package/header (types.sv): default timing constants for 640x480@60, plus colour-bar constants.
- H_TOTAL, V_TOTAL, FB_W, FB_H and ADDR_BITS are derived as localparams in the module.
- Sub-module: vga_timing_gen (counters, sync, blank, parametrised by the timing parameters), reused by other display blocks.
- The delay line is a generic pipe_delay #(WIDTH, DEPTH) instance.

Test Plan:
- Reset: hold rst_n_in=0 for 5 cycles -> vga_hs=vga_vs=1, colours 0, read_addr_out=0; release -> first read_addr_out=0 one cycle later.
- Latency with default parameters and read_data_in=addr[3:0] (BRAM model, latency 2) -> pixel (0,0) appears on pins 4 cycles after hcount=0, with colour matching the address and hs aligned.
- Scaling, SCALE_LOG2=2 -> addresses 0,0,0,0,1,... along line 0; lines 0-3 repeat 0..159; line 4 starts at 160; last active line ends at 19199.
- Buffer select: toggle buf_sel_in=1 mid-frame -> addresses unchanged until next (0,0), then base is 19200; buf_active_out=1.
- Modes: mode 1 with data 4'h3 -> rgb=C,C,C; mode 2 -> hcount 80..159 shows r=F,g=F,b=0; mode 3 -> all 0; blanking always 0.
- frame_done_out: exactly one pulse per 800*525 cycles, at vcount=480, hcount=0; reset asserted at vcount=200 -> counters restart at 0, no spurious pulse.
